hyst_thresh: RTL

- Downstream stage of the non-maximum-suppression (NM) output in the CHIP edge-detection pipeline.
- Consumes the 18x18 NM magnitude stream (5-bit, raster order) and applies double-threshold hysteresis.
- A pixel is an edge if it is strong, or if it is weak and touches a strong pixel in its 3x3 neighbourhood (single-pass, 8-connected).
- Drives the chip-level edge_out bit stream.

---
 rtl/hyst_pkg.sv | 43 ++++
 rtl/hyst_thresh_if.sv | 47 ++++
 rtl/hyst_line_buf.sv | 42 ++++
 rtl/hyst_thresh.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyst_pkg.sv
// ----------------------------------------------------------------------------
// hyst_pkg
//   Shared types and defaults for the hysteresis-threshold stage that follows
//   non-maximum suppression in the edge-detection pipeline.
//
//   Contents:
//     IMG_W_DEF / IMG_H_DEF / MAG_W_DEF : default frame geometry and
//                                         magnitude width
//     pix_class_t                       : per-pixel class (NONE/WEAK/STRONG)
//     state_t                           : controller states (IDLE/RUN/FLUSH)
//     classify()                        : maps threshold comparisons to a class
// ----------------------------------------------------------------------------
package hyst_pkg;

    localparam int IMG_W_DEF = 18;
    localparam int IMG_H_DEF = 18;
    localparam int MAG_W_DEF = 5;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        WEAK   = 2'd1,
        STRONG = 2'd2
    } pix_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Strong wins over weak, so when thr_lo > thr_hi every pixel at or above
    // thr_lo is already strong and the weak set ends up empty by construction.
    function automatic pix_class_t classify(input logic at_hi, input logic at_lo);
        if (at_hi) begin
            return STRONG;
        end else if (at_lo) begin
            return WEAK;
        end else begin
            return NONE;
        end
    endfunction

endpackage

// File: rtl/hyst_thresh_if.sv
// ----------------------------------------------------------------------------
// hyst_thresh_if
//   Pixel-stream handshake between the NM stage, the hysteresis block and the
//   edge_out consumer.
//
//   Signals:
//     in_valid  : mag_in carries a pixel this cycle
//     mag_in    : NM magnitude, raster order
//     in_ready  : block can accept in_valid this cycle
//     out_valid : edge_out is meaningful this cycle
//     edge_out  : final edge decision for the current output pixel
//     out_done  : one-cycle pulse alongside the last output pixel of a frame
//
//   Modports:
//     master : pixel producer / result consumer (e.g. testbench, NM stage)
//     slave  : the hysteresis block itself
// ----------------------------------------------------------------------------
interface hyst_thresh_if #(
    parameter int MAG_W = 5
);

    logic             in_valid;
    logic [MAG_W-1:0] mag_in;
    logic             in_ready;
    logic             out_valid;
    logic             edge_out;
    logic             out_done;

    modport master (
        output in_valid,
        output mag_in,
        input  in_ready,
        input  out_valid,
        input  edge_out,
        input  out_done
    );

    modport slave (
        input  in_valid,
        input  mag_in,
        output in_ready,
        output out_valid,
        output edge_out,
        output out_done
    );

endinterface

// File: rtl/hyst_line_buf.sv
// ----------------------------------------------------------------------------
// hyst_line_buf
//   Depth-DEPTH shift register of 2-bit pixel classes. With DEPTH equal to the
//   frame width, dout presents the class that entered exactly one image row
//   (DEPTH shifts) earlier.
//
//   Ports:
//     clk      : system clock
//     shift_en : advance the line by one pixel
//     din      : class entering the line
//     dout     : class leaving the line (oldest entry)
//
//   Contents are deliberately not reset: the consumer masks every neighbour
//   that could still hold data from a previous frame.
// ----------------------------------------------------------------------------
module hyst_line_buf
    import hyst_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic       clk,
    input  logic       shift_en,
    input  pix_class_t din,
    output pix_class_t dout
);

    pix_class_t mem [DEPTH];

    // Plain shift line: entry 0 takes the new class, every other entry takes
    // its predecessor, all only when the pixel stream advances.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/hyst_thresh.sv
// ----------------------------------------------------------------------------
// hyst_thresh
//   Double-threshold hysteresis on the NM magnitude stream. Each pixel is
//   classed STRONG / WEAK / NONE; a pixel is an edge if it is strong, or weak
//   with at least one strong pixel among its 8 neighbours (single pass).
//
//   Ports:
//     clk        : system clock
//     reset      : asynchronous, active-low reset
//     bus        : hyst_thresh_if.slave pixel stream (in_valid, mag_in,
//                  in_ready, out_valid, edge_out, out_done)
//     thr_hi     : strong threshold, latched on the first pixel of a frame
//     thr_lo     : weak threshold, latched on the first pixel of a frame
//     busy       : a frame is in progress
//     edge_count : edge pixels emitted in the current or last frame
//
//   Build option:
//     HYST_STATS_EN : when defined, edge_count is a live counter; otherwise
//                     edge_count is tied to zero and no counter exists.
//
//   Timing: the output for pixel p is registered in the same clock edge that
//   accepts pixel p+IMG_W+1, so it is visible the cycle after that pixel was
//   presented. After the last input pixel, IMG_W+1 NONE pixels are injected
//   internally to push the remaining outputs out.
// ----------------------------------------------------------------------------
module hyst_thresh
    import hyst_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    hyst_thresh_if.slave                       bus,
    input  logic [MAG_W-1:0]                   thr_hi,
    input  logic [MAG_W-1:0]                   thr_lo,
    output logic                               busy,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0]   edge_count
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PIX_W = $clog2(NPIX);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int COL_W = $clog2(IMG_W);
    localparam int FL_W  = $clog2(IMG_W + 1);
    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [PIX_W-1:0] FIRST_EMIT = PIX_W'(IMG_W + 1);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NPIX - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_W - 1);
    localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(IMG_W);

    state_t           state;
    logic [MAG_W-1:0] thr_hi_q;
    logic [MAG_W-1:0] thr_lo_q;
    logic [PIX_W-1:0] in_count;
    logic [FL_W-1:0]  flush_count;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;

    logic [MAG_W-1:0] hi_eff;
    logic [MAG_W-1:0] lo_eff;
    pix_class_t       pix_cls;
    pix_class_t       new_cls;
    logic             advance;
    logic             emit;

    pix_class_t       lb1_out;
    pix_class_t       lb2_out;
    pix_class_t       col_a [3];
    pix_class_t       col_b [3];
    pix_class_t       win [3][3];
    logic             strong_nb;
    logic             edge_dec;

    logic             mask_top;
    logic             mask_bot;
    logic             mask_left;
    logic             mask_right;

    // Input side: pick the thresholds in force (live inputs on the very first
    // pixel, since they are being latched in that same edge), class the pixel
    // and decide whether the window advances and whether an output is due.
    // In FLUSH the window keeps moving on phantom NONE pixels every cycle.
    always_comb begin
        hi_eff  = (state == IDLE) ? thr_hi : thr_hi_q;
        lo_eff  = (state == IDLE) ? thr_lo : thr_lo_q;
        pix_cls = classify(bus.mag_in >= hi_eff, bus.mag_in >= lo_eff);
        advance = 1'b0;
        emit    = 1'b0;
        new_cls = NONE;
        case (state)
            IDLE: begin
                advance = bus.in_valid;
                new_cls = pix_cls;
            end
            RUN: begin
                advance = bus.in_valid;
                new_cls = pix_cls;
                emit    = bus.in_valid && (in_count >= FIRST_EMIT);
            end
            FLUSH: begin
                advance = 1'b1;
                emit    = 1'b1;
                new_cls = NONE;
            end
            default: begin
                advance = 1'b0;
            end
        endcase
    end

    // Two row delays: lb1 yields the pixel one row above the incoming one,
    // lb2 the pixel two rows above.
    hyst_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk      (clk),
        .shift_en (advance),
        .din      (new_cls),
        .dout     (lb1_out)
    );

    hyst_line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk      (clk),
        .shift_en (advance),
        .din      (lb1_out),
        .dout     (lb2_out)
    );

    // The 3x3 window is the two most recent columns held in col_a/col_b plus
    // the column arriving this cycle. Deciding on that assembled window lets
    // the result be registered in the same edge that accepts the pixel.
    // Like the line buffers, these columns are never reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            col_a    <= col_b;
            col_b[0] <= lb2_out;
            col_b[1] <= lb1_out;
            col_b[2] <= new_cls;
        end
    end

    // Border masking is keyed off the coordinates of the centre pixel about
    // to be emitted; it hides both true off-frame positions and the row
    // wrap-around that a flat raster window would otherwise see.
    assign mask_top   = (out_row == '0);
    assign mask_bot   = (out_row == LAST_ROW);
    assign mask_left  = (out_col == '0);
    assign mask_right = (out_col == LAST_COL);

    // Hysteresis decision for the centre pixel: strong, or weak touching a
    // strong neighbour that survives border masking.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win[r][0] = col_a[r];
            win[r][1] = col_b[r];
        end
        win[0][2] = lb2_out;
        win[1][2] = lb1_out;
        win[2][2] = new_cls;

        strong_nb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) &&
                    (win[r][c] == STRONG) &&
                    !(r == 0 && mask_top) &&
                    !(r == 2 && mask_bot) &&
                    !(c == 0 && mask_left) &&
                    !(c == 2 && mask_right)) begin
                    strong_nb = 1'b1;
                end
            end
        end

        edge_dec = (win[1][1] == STRONG) || ((win[1][1] == WEAK) && strong_nb);
    end

    // Frame controller with registered handshake outputs. IDLE takes pixel 0
    // and latches thresholds, RUN counts input pixels (stalls simply leave
    // everything untouched), FLUSH drains IMG_W+1 phantom pixels and raises
    // out_done with the final output while dropping busy and reopening input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            thr_hi_q      <= '0;
            thr_lo_q      <= '0;
            in_count      <= '0;
            flush_count   <= '0;
            out_row       <= '0;
            out_col       <= '0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.edge_out  <= 1'b0;
            bus.out_done  <= 1'b0;
        end else begin
            bus.out_valid <= emit;
            bus.edge_out  <= emit & edge_dec;
            bus.out_done  <= 1'b0;

            if (emit) begin
                if (out_col == LAST_COL) begin
                    out_col <= '0;
                    out_row <= out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        thr_hi_q <= thr_hi;
                        thr_lo_q <= thr_lo;
                        in_count <= PIX_W'(1);
                        out_row  <= '0;
                        out_col  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        if (in_count == LAST_PIX) begin
                            state        <= FLUSH;
                            bus.in_ready <= 1'b0;
                            flush_count  <= '0;
                        end else begin
                            in_count <= in_count + PIX_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_count == LAST_FLUSH) begin
                        bus.out_done <= 1'b1;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        flush_count <= flush_count + FL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HYST_STATS_EN
    logic [CNT_W-1:0] edge_cnt_q;

    // Per-frame edge tally: cleared by the first pixel of a new frame, bumped
    // with each emitted edge, and left alone between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt_q <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            edge_cnt_q <= '0;
        end else if (emit && edge_dec) begin
            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
    end

    assign edge_count = edge_cnt_q;
`else
    assign edge_count = '0;
`endif

endmodule
